button_debouncer: RTL and testbench



---
 rtl/logic_gates_pkg.sv | 24 ++
 rtl/sync_chain.sv | 35 +++
 rtl/button_debouncer.sv | 147 ++++++++++++++
 tb/tb_button_debouncer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gates_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_gates_pkg
// Purpose : Shared types and defaults for the basic-gate library front end.
//           Holds the debouncer state encoding and its default parameters.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package logic_gates_pkg;

  // Debouncer states. ST_* are settled levels, CHK_* are candidate changes
  // that are still being qualified.
  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } debounce_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage : logic_gates_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Purpose : Single-bit synchroniser, a chain of STAGES reset-to-0 flops.
//           Reusable for any raw asynchronous input.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           d_i   - raw asynchronous input bit
//           q_o   - synchronised bit (last flop of the chain)
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Bit 0 is the metastability-exposed flop; nothing reads it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Purpose : Synchronises one raw input, accepts a level change only after
//           DEBOUNCE_CYCLES consecutive agreeing samples, emits one-cycle
//           rise/fall pulses and counts accepted rises (wrapping).
// Ports   : clk        - clock
//           rst_n      - asynchronous active-low reset
//           a_raw      - raw asynchronous input
//           clr_count  - synchronous clear of rise_count (wins over a rise)
//           a_clean    - debounced level
//           rise_pulse - one cycle high after an accepted 0->1
//           fall_pulse - one cycle high after an accepted 1->0
//           rise_count - accepted rises modulo 2^COUNT_W
// Revision: 1.0 - initial release
// ============================================================================
module button_debouncer
  import logic_gates_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_raw,
  input  logic               clr_count,
  output logic               a_clean,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [COUNT_W-1:0] rise_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a single required sample a change is accepted straight from ST_*.
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic                  s;
  debounce_state_t       state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  a_clean_q;
  logic                  rise_q;
  logic                  fall_q;
  logic [COUNT_W-1:0]    count_q;
  logic                  accept_rise;
  logic                  accept_fall;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (a_raw),
    .q_o   (s)
  );

  // Edges on which a change is accepted this cycle; shared by the pulse
  // registers and the rise counter so both move on the same clock.
  assign accept_rise = s  && (((state_q == ST_LOW)   && ONE_SHOT) ||
                              ((state_q == CHK_HIGH) && (cnt_q == CNT_LAST)));
  assign accept_fall = !s && (((state_q == ST_HIGH)  && ONE_SHOT) ||
                              ((state_q == CHK_LOW)  && (cnt_q == CNT_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      a_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      rise_q <= accept_rise;
      fall_q <= accept_fall;

      unique case (state_q)
        ST_LOW: begin
          if (s) begin
            if (ONE_SHOT) begin
              state_q   <= ST_HIGH;
              a_clean_q <= 1'b1;
            end else begin
              state_q <= CHK_HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            // Bounce: fall back without touching the output.
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_HIGH;
            cnt_q     <= '0;
            a_clean_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            if (ONE_SHOT) begin
              state_q   <= ST_LOW;
              a_clean_q <= 1'b0;
            end else begin
              state_q <= CHK_LOW;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        CHK_LOW: begin
          if (s) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            a_clean_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
        end
      endcase

      // Clear has priority over a simultaneous accepted rise.
      if (clr_count) begin
        count_q <= '0;
      end else if (accept_rise) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign a_clean    = a_clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_count = count_q;

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_debouncer
// Purpose : Self-checking bench for button_debouncer. A reference model
//           counts consecutive disagreeing synchronised samples and queues
//           each expected pulse (edge index, direction, count); a monitor
//           pops and compares whenever a pulse is due or seen.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int CW = 8;

  typedef struct {
    int            ecyc;
    bit            rise;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          a_raw     = 1'b0;
  logic          clr_count = 1'b0;
  logic          a_clean;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] rise_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [S-1:0]  m_sync = '0;
  bit            m_lvl  = 1'b0;
  int            m_run  = 0;
  logic [CW-1:0] m_cnt  = '0;
  int            edge_n = 0;
  bit            m_s, m_rose, m_fell;
  exp_t          exp_q[$];

  button_debouncer #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .COUNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_raw      (a_raw),
    .clr_count  (clr_count),
    .a_clean    (a_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_count (rise_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    a_raw = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a change is accepted once D consecutive synchronised
  // samples disagree with the current accepted level.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sync = '0;
        m_lvl  = 1'b0;
        m_run  = 0;
        m_cnt  = '0;
        exp_q.delete();
      end else begin
        edge_n++;
        m_s    = m_sync[S-1];
        m_rose = 1'b0;
        m_fell = 1'b0;
        if (m_s != m_lvl) begin
          m_run++;
          if (m_run == D) begin
            m_lvl  = m_s;
            m_run  = 0;
            m_rose = m_s;
            m_fell = !m_s;
          end
        end else begin
          m_run = 0;
        end
        if (clr_count)   m_cnt = '0;
        else if (m_rose) m_cnt = m_cnt + 1'b1;
        if (m_rose || m_fell) exp_q.push_back('{edge_n, m_rose, m_cnt});
        m_sync = {m_sync[S-2:0], a_raw};
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   exp_p;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("level", a_clean, m_lvl);
        chk("count", rise_count, m_cnt);
        chk("pulse_exclusive", rise_pulse & fall_pulse, 1'b0);
        exp_p = (exp_q.size() > 0) && (exp_q[0].ecyc == edge_n);
        chk("pulse_present", rise_pulse | fall_pulse, exp_p);
        if (exp_p) begin
          e = exp_q.pop_front();
          chk("pulse_dir", rise_pulse, e.rise);
          chk("pulse_count", rise_count, e.cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset values, no clock edge yet
    #1;
    chk("rst_a_clean", a_clean, 1'b0);
    chk("rst_rise", rise_pulse, 1'b0);
    chk("rst_fall", fall_pulse, 1'b0);
    chk("rst_count", rise_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 4);

    // Clean rise: accepted after S+D edges
    a_raw = 1'b1;
    repeat (5) @(negedge clk);
    chk("rise_too_early", a_clean, 1'b0);
    @(negedge clk);
    chk("rise_a_clean", a_clean, 1'b1);
    chk("rise_pulse_on", rise_pulse, 1'b1);
    chk("rise_count_1", rise_count, 1);
    @(negedge clk);
    chk("rise_pulse_off", rise_pulse, 1'b0);
    hold(1'b1, 6);

    // Fall
    hold(1'b0, 12);
    chk("fall_a_clean", a_clean, 1'b0);
    chk("fall_count_kept", rise_count, 1);

    // Bounce: high 3 cycles, then low, repeated
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    hold(1'b0, 8);
    chk("bounce_a_clean", a_clean, 1'b0);
    chk("bounce_count", rise_count, 1);

    // Asynchronous reset mid-cycle while high
    hold(1'b1, 10);
    chk("pre_reset_count", rise_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_clean", a_clean, 1'b0);
    chk("async_rst_rise", rise_pulse, 1'b0);
    chk("async_rst_fall", fall_pulse, 1'b0);
    chk("async_rst_count", rise_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 10);
    chk("post_reset_rise_count", rise_count, 1);
    hold(1'b0, 12);

    // Reset while in CHK_HIGH with cnt=2
    a_raw = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midchk_a_clean", a_clean, 1'b0);
    chk("midchk_count", rise_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midchk_latency_early", rise_pulse, 1'b0);
    @(negedge clk);
    chk("midchk_latency_pulse", rise_pulse, 1'b1);
    chk("midchk_count_1", rise_count, 1);
    hold(1'b1, 4);
    hold(1'b0, 12);

    // Counter wrap: clear, then 256 accepted rises
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_count", rise_count, 0);
    for (int i = 0; i < 256; i++) begin
      hold(1'b1, 7);
      hold(1'b0, 7);
    end
    chk("wrap_count", rise_count, 0);
    hold(1'b1, 7);
    hold(1'b0, 7);
    chk("after_wrap_count", rise_count, 1);

    // Clear on the same edge as an accepted rise
    a_raw = 1'b1;
    repeat (5) @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_vs_rise_pulse", rise_pulse, 1'b1);
    chk("clr_vs_rise_count", rise_count, 0);
    hold(1'b1, 6);
    hold(1'b0, 10);

    // Randomised input with occasional clears
    for (int i = 0; i < 400; i++) begin
      logic v;
      int   n;
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) begin
        clr_count = ($urandom_range(0, 31) == 0);
        a_raw     = v;
        @(negedge clk);
      end
    end
    clr_count = 1'b0;
    hold(1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_button_debouncer
`default_nettype wire
